// File: rtl/pcm_decimator.sv
// Decimates one channel of an I2S word stream by 2^LOG2_RATIO; 1-cycle accept-to-valid latency, single-entry output.
// Input stalls only while an output is held and downstream is not ready. Optional macro: PCM_DECIMATOR_ROUND_EN.
module pcm_decimator #(
    parameter int LOG2_RATIO = 2,
    parameter int CHANNEL    = 0,
    parameter int FRAME_LEN  = 256
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tlast
);

    localparam int AW = 24 + LOG2_RATIO;
    localparam int FW = $clog2(FRAME_LEN);
    localparam logic [FW-1:0] LAST_IDX = FW'(FRAME_LEN - 1);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic signed [AW-1:0]    r_acc;
    logic [LOG2_RATIO-1:0]   r_count;
    logic [FW-1:0]           r_frame;
    logic [15:0]             r_dat;

    logic                    w_s_xfer;
    logic                    w_m_xfer;
    logic                    w_acc_en;
    logic                    w_last_sample;
    logic signed [23:0]      w_sample;
    logic signed [AW-1:0]    w_sum;
    logic [15:0]             w_result;

    assign w_s_xfer      = s_axis_tvalid & s_axis_tready;
    assign w_m_xfer      = m_axis_tvalid & m_axis_tready;
    assign w_acc_en      = w_s_xfer & (s_axis_tlast == CHANNEL[0]);
    assign w_last_sample = w_acc_en & (&r_count);
    assign w_sample      = s_axis_tdata[31:8];
    assign w_sum         = r_acc + {{LOG2_RATIO{w_sample[23]}}, w_sample};

`ifdef PCM_DECIMATOR_ROUND_EN
    // One guard bit so the half-LSB bias cannot wrap a full-scale positive sum.
    logic signed [AW:0]  w_rnd_sum;
    logic signed [16:0]  w_rnd_q;

    assign w_rnd_sum = {w_sum[AW-1], w_sum} + ((AW+1)'(1) << (LOG2_RATIO + 7));
    assign w_rnd_q   = w_rnd_sum[AW:LOG2_RATIO+8];
    assign w_result  = (w_rnd_q[16] != w_rnd_q[15]) ? (w_rnd_q[16] ? 16'h8000 : 16'h7FFF)
                                                    : w_rnd_q[15:0];

    logic w_unused;
    assign w_unused = ^s_axis_tdata[7:0];
`else
    // Slicing the sum directly is the arithmetic right shift followed by [23:8].
    assign w_result = w_sum[LOG2_RATIO+23:LOG2_RATIO+8];

    logic w_unused;
    assign w_unused = ^{s_axis_tdata[7:0], w_sum[LOG2_RATIO+7:0]};
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_acc   <= '0;
            r_count <= '0;
            r_dat   <= '0;
        end else if (w_acc_en) begin
            if (w_last_sample) begin
                r_acc   <= '0;
                r_count <= '0;
                r_dat   <= w_result;
            end else begin
                r_acc   <= w_sum;
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_frame <= '0;
        end else if (w_m_xfer) begin
            r_frame <= (r_frame == LAST_IDX) ? '0 : r_frame + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM: if (w_last_sample) w_state_nxt = HOLD;
            HOLD:  if (w_last_sample) w_state_nxt = HOLD;
                   else if (w_m_xfer) w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        m_axis_tvalid = (r_state == HOLD);
        m_axis_tlast  = (r_state == HOLD) && (r_frame == LAST_IDX);
        s_axis_tready = (r_state == ACCUM) || m_axis_tready;
    end

    assign m_axis_tdata = r_dat;

endmodule

// File: doc/pcm_decimator.md
PCM_DECIMATOR -- requirements
Module: pcm_decimator

Interface
REQ-001 SHALL have parameter LOG2_RATIO, default 2, decimation ratio N = 2^LOG2_RATIO (legal 1..6).
REQ-002 SHALL have parameter CHANNEL, default 0: 0 selects words with s_axis_tlast=0 (left), 1 selects s_axis_tlast=1 (right).
REQ-003 SHALL have parameter FRAME_LEN, default 256, outputs per frame (legal 2..65535).
REQ-004 SHALL have port clk_in  input  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port s_axis_tvalid  input  1  input word valid (from i2s_receiver).
REQ-007 SHALL have port s_axis_tready  output  1  input word accepted when high with tvalid.
REQ-008 SHALL have port s_axis_tdata  input  32  I2S word; signed 24-bit sample in [31:8], [7:0] ignored.
REQ-009 SHALL have port s_axis_tlast  input  1  channel tag (1 = right word of stereo frame).
REQ-010 SHALL have port m_axis_tvalid  output  1  decimated sample valid.
REQ-011 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-012 SHALL have port m_axis_tdata  output  16  signed decimated sample.
REQ-013 SHALL have port m_axis_tlast  output  1  high on last output of each FRAME_LEN block.

Function
REQ-014 SHALL implement two states: ACCUM (m_axis_tvalid=0) and HOLD (m_axis_tvalid=1).
REQ-015 SHALL drive s_axis_tready = (state==ACCUM) | m_axis_tready, combinationally.
REQ-016 SHALL accept and discard, without accumulating, every transferred word whose tlast does not match CHANNEL.
REQ-017 SHALL sign-extend each selected sample into a (24+LOG2_RATIO)-bit accumulator and increment a sample count.
REQ-018 SHALL, on transfer of the N-th selected sample, register result into m_axis_tdata, go to HOLD, clear accumulator and count; m_axis_tvalid rises the next cycle (1-cycle latency).
REQ-019 SHALL compute result = (sum >>> LOG2_RATIO)[23:8] (arithmetic, floor) when rounding is compiled out.
REQ-020 SHALL hold m_axis_tdata/m_axis_tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-021 SHALL return to ACCUM after an output transfer unless the same cycle completes a new N-th sample, in which case it stays in HOLD with the new result.
REQ-022 SHALL accumulate an input word transferring in the same cycle as an output transfer (no sample lost).
REQ-023 SHALL count output transfers modulo FRAME_LEN, asserting m_axis_tlast on the output whose index is FRAME_LEN-1, then wrapping to 0.

Reset
REQ-024 SHALL on rst_in=1 immediately force state ACCUM, accumulator 0, sample count 0, frame count 0, m_axis_tvalid 0, m_axis_tdata 0x0000, m_axis_tlast 0.
REQ-025 SHALL discard any partial accumulation or pending output on reset mid-operation; s_axis_tready reads 1 after reset.

Configuration
REQ-026 SHALL, with macro PCM_DECIMATOR_ROUND_EN defined, compute result = sat16((sum + 2^(LOG2_RATIO+7)) >>> (LOG2_RATIO+8)), saturating to 0x7FFF/0x8000.
REQ-027 SHALL, without PCM_DECIMATOR_ROUND_EN, use truncation per REQ-019 with no rounding or saturation logic.

Verification
REQ-028 Basic: LOG2_RATIO=2, four left words 0x00100000, m_axis_tready=1 -> one output 0x0010, tvalid one cycle after 4th transfer.
REQ-029 Channel select: left 0xFFF00000 x4 interleaved with right 0x7FFFFF00 x4, CHANNEL=0 -> single output 0xFFF0; right words all accepted.
REQ-030 Rounding: four left words 0x00008000 -> 0x0000 without macro, 0x0001 with PCM_DECIMATOR_ROUND_EN; four 0x7FFFFF00 -> 0x7FFF both builds.
REQ-031 Backpressure: m_axis_tready=0 for 10 cycles after an output -> tdata stable, s_axis_tready=0; on tready=1 with input valid, output and input transfer same cycle.
REQ-032 Framing: FRAME_LEN=2, 16 left words -> 4 outputs with tlast pattern 0,1,0,1.
REQ-033 Reset: assert rst_in after 2 of 4 samples -> all outputs 0; next 4 samples 0x00200000 -> output 0x0020.
